// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round: two-stage normalize / round / pack stage that sits
// behind the 26-bit fraction multiplier of the single-precision multiply path.
// Stage 1 normalizes and decides rounding; stage 2 applies the increment,
// detects over/underflow and packs the binary32 result with RISC-V fflags.
module fp_mul_norm_round #(
   parameter int BIAS    = 127,
   parameter int EXP_MAX = 255
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sign_in,
   input  logic [9:0]  exp_in,
   input  logic [25:0] frac_in,
   input  logic        ovf_in,
   input  logic        sticky_in,
   input  logic [2:0]  frm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [4:0]  fflags
);

   typedef enum logic [2:0] {
      RmRne = 3'b000,
      RmRtz = 3'b001,
      RmRdn = 3'b010,
      RmRup = 3'b011,
      RmRmm = 3'b100
   } rm_e;

   localparam logic signed [10:0] ExpMaxS   = 11'(EXP_MAX);
   localparam logic [7:0]         InfExp    = 8'(EXP_MAX);
   localparam logic [7:0]         MaxFinExp = 8'(2 * BIAS);

   // pipeline state
   logic        s1_valid_q;
   logic        s1_sign_q;
   logic [9:0]  s1_exp_q;
   logic [22:0] s1_mant_q;
   logic        s1_rup_q;
   logic        s1_nx_q;
   logic [2:0]  s1_frm_q;
   logic        s2_valid_q;
   logic [31:0] result_q;
   logic [4:0]  fflags_q;

   // stage-1 next-state values
   logic [9:0]  s1_exp_d;
   logic [22:0] s1_mant_d;
   logic        s1_rup_d;
   logic        s1_nx_d;
   logic        guardBit;
   logic        stickyBit;

   // stage-2 next-state values
   logic [23:0]        sum;
   logic signed [10:0] expPost;
   logic               underflow;
   logic               overflow;
   logic [31:0]        result_d;
   logic [4:0]         fflags_d;

   logic adv1;
   logic adv2;

   // a stage may load when it is empty or its contents move on this cycle
   assign adv2      = !s2_valid_q || out_ready;
   assign adv1      = !s1_valid_q || adv2;
   assign in_ready  = adv1;
   assign out_valid = s2_valid_q;
   assign result    = result_q;
   assign fflags    = fflags_q;

   // normalize the raw product to 1.x form and pick the rounding direction
   always_comb begin
      s1_exp_d  = exp_in;
      s1_mant_d = frac_in[24:2];
      guardBit  = frac_in[1];
      stickyBit = frac_in[0] | sticky_in;
      if (ovf_in) begin
         s1_exp_d  = exp_in + 10'd1;
         s1_mant_d = frac_in[25:3];
         guardBit  = frac_in[2];
         stickyBit = (|frac_in[1:0]) | sticky_in;
      end
      s1_nx_d = guardBit | stickyBit;
      case (frm)
         RmRtz:   s1_rup_d = 1'b0;
         RmRdn:   s1_rup_d = sign_in & s1_nx_d;
         RmRup:   s1_rup_d = !sign_in & s1_nx_d;
         RmRmm:   s1_rup_d = guardBit;
         default: s1_rup_d = guardBit & (stickyBit | s1_mant_d[0]);
      endcase
   end

   // stage-1 register: captures a beat whenever the input handshake fires
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_exp_q   <= '0;
         s1_mant_q  <= '0;
         s1_rup_q   <= 1'b0;
         s1_nx_q    <= 1'b0;
         s1_frm_q   <= '0;
      end else if (adv1) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sign_q <= sign_in;
            s1_exp_q  <= s1_exp_d;
            s1_mant_q <= s1_mant_d;
            s1_rup_q  <= s1_rup_d;
            s1_nx_q   <= s1_nx_d;
            s1_frm_q  <= frm;
         end
      end
   end

   // apply the increment, then classify as underflow, overflow or normal
   always_comb begin
      sum       = {1'b0, s1_mant_q} + {23'd0, s1_rup_q};
      expPost   = {s1_exp_q[9], s1_exp_q} + {10'd0, sum[23]};
      underflow = $signed(s1_exp_q) <= 10'sd0;
      overflow  = expPost >= ExpMaxS;
      result_d  = {s1_sign_q, expPost[7:0], sum[22:0]};
      fflags_d  = {4'b0000, s1_nx_q};
      if (underflow) begin
         result_d = {s1_sign_q, 31'd0};
         fflags_d = 5'b00011;
      end else if (overflow) begin
         fflags_d = 5'b00101;
         case (s1_frm_q)
            RmRtz:   result_d = {s1_sign_q, MaxFinExp, 23'h7FFFFF};
            RmRdn:   result_d = s1_sign_q ? {1'b1, InfExp, 23'd0}
                                          : {1'b0, MaxFinExp, 23'h7FFFFF};
            RmRup:   result_d = s1_sign_q ? {1'b1, MaxFinExp, 23'h7FFFFF}
                                          : {1'b0, InfExp, 23'd0};
            default: result_d = {s1_sign_q, InfExp, 23'd0};
         endcase
      end
   end

   // stage-2 register: output holds still while the consumer stalls
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         fflags_q   <= '0;
      end else if (adv2) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            result_q <= result_d;
            fflags_q <= fflags_d;
         end
      end
   end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// tb_fp_mul_norm_round: directed vectors for the normalize/round/pack stage,
// plus a backpressure stream and an asynchronous reset mid-stream.
module tb_fp_mul_norm_round;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        in_valid;
   logic        in_ready;
   logic        sign_in;
   logic [9:0]  exp_in;
   logic [25:0] frac_in;
   logic        ovf_in;
   logic        sticky_in;
   logic [2:0]  frm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [4:0]  fflags;

   typedef struct packed {
      logic        sign;
      logic [9:0]  expIn;
      logic [25:0] frac;
      logic        ovf;
      logic        sticky;
      logic [2:0]  rm;
      logic [31:0] expRes;
      logic [4:0]  expFlags;
   } vec_t;

   localparam int NumVecs = 20;
   vec_t vecs[NumVecs];

   int testsRun    = 0;
   int testsFailed = 0;

   fp_mul_norm_round dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sign_in   (sign_in),
      .exp_in    (exp_in),
      .frac_in   (frac_in),
      .ovf_in    (ovf_in),
      .sticky_in (sticky_in),
      .frm       (frm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .fflags    (fflags)
   );

   // free-running clock, 10 time units per period
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s[%0d]: got %h, expected %h", name, idx, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      sign_in   = v.sign;
      exp_in    = v.expIn;
      frac_in   = v.frac;
      ovf_in    = v.ovf;
      sticky_in = v.sticky;
      frm       = v.rm;
      in_valid  = 1'b1;
   endtask

   task automatic runVector(input int idx);
      int lat;
      @(negedge CLK);
      applyStimulus(vecs[idx]);
      #1;
      checkOutput("in_ready", idx, 32'(in_ready), 32'd1);
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
         @(negedge CLK);
         lat++;
      end
      checkOutput("latency", idx, 32'(lat), 32'd2);
      checkOutput("result", idx, result, vecs[idx].expRes);
      checkOutput("fflags", idx, 32'(fflags), 32'(vecs[idx].expFlags));
   endtask

   initial begin
      vec_t        head;
      vec_t        q[$];
      int          sent;
      int          drained;
      int          seen;
      logic        prevStall;
      logic [31:0] prevRes;
      logic [4:0]  prevFlags;

      //               sign expIn   frac          ovf stk rm      result        flags
      vecs[0]  = '{1'b0, 10'd127, 26'h2000000, 1'b0, 1'b0, 3'd0, 32'h3F800000, 5'b00000};
      vecs[1]  = '{1'b0, 10'd127, 26'h0800000, 1'b1, 1'b0, 3'd0, 32'h40100000, 5'b00000};
      vecs[2]  = '{1'b0, 10'd127, 26'h3FFFFFF, 1'b0, 1'b0, 3'd0, 32'h40000000, 5'b00001};
      vecs[3]  = '{1'b0, 10'd127, 26'h3FFFFFF, 1'b0, 1'b0, 3'd1, 32'h3FFFFFFF, 5'b00001};
      vecs[4]  = '{1'b0, 10'd254, 26'h0000000, 1'b1, 1'b0, 3'd0, 32'h7F800000, 5'b00101};
      vecs[5]  = '{1'b0, 10'd254, 26'h0000000, 1'b1, 1'b0, 3'd1, 32'h7F7FFFFF, 5'b00101};
      vecs[6]  = '{1'b1, 10'd254, 26'h0000000, 1'b1, 1'b0, 3'd2, 32'hFF800000, 5'b00101};
      vecs[7]  = '{1'b1, 10'd254, 26'h0000000, 1'b1, 1'b0, 3'd3, 32'hFF7FFFFF, 5'b00101};
      vecs[8]  = '{1'b1, 10'd0,   26'h2000000, 1'b0, 1'b0, 3'd0, 32'h80000000, 5'b00011};
      vecs[9]  = '{1'b1, 10'd127, 26'h2000001, 1'b0, 1'b0, 3'd2, 32'hBF800001, 5'b00001};
      vecs[10] = '{1'b1, 10'd127, 26'h2000001, 1'b0, 1'b0, 3'd3, 32'hBF800000, 5'b00001};
      vecs[11] = '{1'b0, 10'd127, 26'h2000002, 1'b0, 1'b0, 3'd0, 32'h3F800000, 5'b00001};
      vecs[12] = '{1'b0, 10'd127, 26'h2000002, 1'b0, 1'b0, 3'd4, 32'h3F800001, 5'b00001};
      vecs[13] = '{1'b0, 10'd127, 26'h2000006, 1'b0, 1'b0, 3'd0, 32'h3F800002, 5'b00001};
      vecs[14] = '{1'b0, 10'd127, 26'h2000006, 1'b0, 1'b0, 3'd7, 32'h3F800002, 5'b00001};
      vecs[15] = '{1'b0, 10'h3F6, 26'h2000000, 1'b0, 1'b0, 3'd0, 32'h00000000, 5'b00011};
      vecs[16] = '{1'b0, 10'd1,   26'h2000000, 1'b0, 1'b0, 3'd0, 32'h00800000, 5'b00000};
      vecs[17] = '{1'b0, 10'd254, 26'h3FFFFFF, 1'b0, 1'b0, 3'd0, 32'h7F800000, 5'b00101};
      vecs[18] = '{1'b0, 10'd0,   26'h0000000, 1'b1, 1'b0, 3'd0, 32'h00800000, 5'b00000};
      vecs[19] = '{1'b0, 10'd127, 26'h2000000, 1'b0, 1'b1, 3'd3, 32'h3F800001, 5'b00001};

      nRST      = 1'b0;
      in_valid  = 1'b0;
      sign_in   = 1'b0;
      exp_in    = '0;
      frac_in   = '0;
      ovf_in    = 1'b0;
      sticky_in = 1'b0;
      frm       = '0;
      out_ready = 1'b1;

      #3;
      checkOutput("rst_out_valid", 0, 32'(out_valid), 32'd0);
      checkOutput("rst_result", 0, result, 32'd0);
      checkOutput("rst_fflags", 0, 32'(fflags), 32'd0);
      checkOutput("rst_in_ready", 0, 32'(in_ready), 32'd1);
      @(negedge CLK);
      nRST = 1'b1;

      for (int i = 0; i < NumVecs; i++) begin
         runVector(i);
      end

      // backpressure stream: four beats, consumer stalls on cycles 0-2 and 4-5
      sent      = 0;
      drained   = 0;
      prevStall = 1'b0;
      prevRes   = '0;
      prevFlags = '0;
      for (int c = 0; c < 30 && drained < 4; c++) begin
         @(negedge CLK);
         out_ready = !(c < 3 || c == 4 || c == 5);
         if (sent < 4) applyStimulus(vecs[sent]);
         else in_valid = 1'b0;
         #1;
         if (c == 2) checkOutput("in_ready_full", c, 32'(in_ready), 32'd0);
         if (prevStall && out_valid) begin
            checkOutput("hold_result", c, result, prevRes);
            checkOutput("hold_fflags", c, 32'(fflags), 32'(prevFlags));
         end
         prevStall = out_valid && !out_ready;
         prevRes   = result;
         prevFlags = fflags;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checkOutput("extra_beat", c, 32'd1, 32'd0);
            end else begin
               head = q.pop_front();
               checkOutput("stream_result", drained, result, head.expRes);
               checkOutput("stream_fflags", drained, 32'(fflags), 32'(head.expFlags));
            end
            drained++;
         end
         if (in_valid && in_ready) begin
            q.push_back(vecs[sent]);
            sent++;
         end
      end
      @(negedge CLK);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("beats_drained", 0, 32'(drained), 32'd4);
      checkOutput("queue_empty", 0, 32'(q.size()), 32'd0);

      // asynchronous reset while a result is waiting and another is in flight
      @(negedge CLK);
      applyStimulus(vecs[0]);
      @(negedge CLK);
      applyStimulus(vecs[1]);
      @(negedge CLK);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      checkOutput("pre_rst_valid", 0, 32'(out_valid), 32'd1);
      #2;
      nRST = 1'b0;
      #1;
      checkOutput("async_out_valid", 0, 32'(out_valid), 32'd0);
      checkOutput("async_result", 0, result, 32'd0);
      checkOutput("async_fflags", 0, 32'(fflags), 32'd0);
      @(negedge CLK);
      nRST      = 1'b1;
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      checkOutput("post_rst_in_ready", 0, 32'(in_ready), 32'd1);
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         if (out_valid) seen++;
      end
      checkOutput("no_ghost_beats", 0, 32'(seen), 32'd0);

      // pipeline still usable after the reset
      runVector(2);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
